// File: rtl/ssd1351_spi_sink.sv
// SSD1351 4-wire SPI receiver: deserialises D/C-qualified bytes, tracks the
// column/row window and emits one strobe per completed RGB565 pixel.
module ssd1351_spi_sink #(
  parameter int c_x_size = 128,
  parameter int c_y_size = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_csn,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  input  logic        spi_dc,
  input  logic        spi_resn,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_dc,
  output logic        pix_valid,
  output logic [6:0]  pix_x,
  output logic [6:0]  pix_y,
  output logic [15:0] pix_color
);

  localparam int XW = (c_x_size > 1) ? $clog2(c_x_size) : 1;
  localparam int YW = (c_y_size > 1) ? $clog2(c_y_size) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(c_x_size - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(c_y_size - 1);

  typedef enum logic [2:0] {
    IDLE, CADDR0, CADDR1, RADDR0, RADDR1, WRAM, SKIP
  } state_t;

  state_t          state_q, state_d;
  logic            sclk_q, sclk_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [6:0]      sr_q, sr_d;
  logic            byte_valid_q, byte_valid_d;
  logic [7:0]      byte_data_q, byte_data_d;
  logic            byte_dc_q, byte_dc_d;
  logic            phase_q, phase_d;
  logic [7:0]      pix_hi_q, pix_hi_d;
  logic [XW-1:0]   col_start_q, col_start_d, col_end_q, col_end_d, col_ptr_q, col_ptr_d;
  logic [YW-1:0]   row_start_q, row_start_d, row_end_q, row_end_d, row_ptr_q, row_ptr_d;
  logic            pix_valid_q, pix_valid_d;
  logic [6:0]      pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [15:0]     pix_color_q, pix_color_d;

  logic rise;
  logic byte_go;

  // Panel reset suppresses both edge capture and byte decode in the same cycle.
  assign rise    = spi_clk & ~sclk_q & ~spi_csn & spi_resn;
  assign byte_go = byte_valid_q & spi_resn;

  always_comb begin
    state_d      = state_q;
    sclk_d       = spi_clk;
    bit_cnt_d    = bit_cnt_q;
    sr_d         = sr_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    byte_dc_d    = byte_dc_q;
    phase_d      = phase_q;
    pix_hi_d     = pix_hi_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    col_ptr_d    = col_ptr_q;
    row_start_d  = row_start_q;
    row_end_d    = row_end_q;
    row_ptr_d    = row_ptr_q;
    pix_valid_d  = 1'b0;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_color_d  = pix_color_q;

    if (spi_csn) begin
      bit_cnt_d = 3'd0;
    end else if (rise) begin
      sr_d      = {sr_q[5:0], spi_mosi};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_valid_d = 1'b1;
        byte_data_d  = {sr_q, spi_mosi};
        byte_dc_d    = spi_dc;
      end
    end

    if (byte_go) begin
      if (!byte_dc_q) begin
        phase_d = 1'b0;
        case (byte_data_q)
          8'h15:   state_d = CADDR0;
          8'h75:   state_d = RADDR0;
          8'h5C: begin
            state_d   = WRAM;
            col_ptr_d = col_start_q;
            row_ptr_d = row_start_q;
          end
          default: state_d = SKIP;
        endcase
      end else begin
        case (state_q)
          CADDR0: begin
            col_start_d = byte_data_q[XW-1:0];
            state_d     = CADDR1;
          end
          CADDR1: begin
            col_end_d = byte_data_q[XW-1:0];
            col_ptr_d = col_start_q;
            state_d   = SKIP;
          end
          RADDR0: begin
            row_start_d = byte_data_q[YW-1:0];
            state_d     = RADDR1;
          end
          RADDR1: begin
            row_end_d = byte_data_q[YW-1:0];
            row_ptr_d = row_start_q;
            state_d   = SKIP;
          end
          WRAM: begin
            if (!phase_q) begin
              pix_hi_d = byte_data_q;
              phase_d  = 1'b1;
            end else begin
              phase_d     = 1'b0;
              pix_valid_d = 1'b1;
              pix_x_d     = 7'(col_ptr_q);
              pix_y_d     = 7'(row_ptr_q);
              pix_color_d = {pix_hi_q, byte_data_q};
              // Column runs first; reaching col_end wraps it and steps the row.
              if (col_ptr_q == col_end_q) begin
                col_ptr_d = col_start_q;
                row_ptr_d = (row_ptr_q == row_end_q) ? row_start_q : row_ptr_q + YW'(1);
              end else begin
                col_ptr_d = col_ptr_q + XW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end

    if (!spi_resn) begin
      state_d     = IDLE;
      bit_cnt_d   = 3'd0;
      sr_d        = 7'd0;
      phase_d     = 1'b0;
      col_start_d = '0;
      col_end_d   = X_LAST;
      col_ptr_d   = '0;
      row_start_d = '0;
      row_end_d   = Y_LAST;
      row_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sclk_q       <= 1'b0;
      bit_cnt_q    <= 3'd0;
      sr_q         <= 7'd0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'd0;
      byte_dc_q    <= 1'b0;
      phase_q      <= 1'b0;
      pix_hi_q     <= 8'd0;
      col_start_q  <= '0;
      col_end_q    <= X_LAST;
      col_ptr_q    <= '0;
      row_start_q  <= '0;
      row_end_q    <= Y_LAST;
      row_ptr_q    <= '0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= 7'd0;
      pix_y_q      <= 7'd0;
      pix_color_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      sclk_q       <= sclk_d;
      bit_cnt_q    <= bit_cnt_d;
      sr_q         <= sr_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_dc_q    <= byte_dc_d;
      phase_q      <= phase_d;
      pix_hi_q     <= pix_hi_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      col_ptr_q    <= col_ptr_d;
      row_start_q  <= row_start_d;
      row_end_q    <= row_end_d;
      row_ptr_q    <= row_ptr_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_color_q  <= pix_color_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign byte_dc    = byte_dc_q;
  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_color  = pix_color_q;

endmodule

// File: doc/ssd1351_spi_sink.md
# ssd1351_spi_sink

Receiving end of the SSD1351 4-wire SPI link that `oled_video` drives. It decodes the byte stream (D/C-qualified) into column/row window commands and RAM-write pixel data. For each completed pixel it emits a one-cycle strobe with x, y and RGB565 color, so a frame store or scoreboard can rebuild the displayed image. It sits beside the OLED pins in loopback/verification builds and shares the pixel clock with the transmitter.

## Interface
Parameters:
- `c_x_size`, 128, display columns (power of two, ≤128)
- `c_y_size`, 128, display rows (power of two, ≤128)

Ports:
- `clk`  in  1  system clock; every SPI input is generated in this clock domain
- `rst`  in  1  asynchronous, active-low reset
- `spi_csn`  in  1  chip select, active low
- `spi_clk`  in  1  SPI clock; MOSI and DC are sampled on its rising edge
- `spi_mosi`  in  1  serial data, MSB first
- `spi_dc`  in  1  0 = command byte, 1 = data byte; sampled with bit 0 of the byte
- `spi_resn`  in  1  panel reset, active low; acts as a synchronous decoder clear
- `byte_valid`  out  1  one-cycle pulse, byte complete
- `byte_data`  out  8  last completed byte
- `byte_dc`  out  1  D/C value of the last completed byte
- `pix_valid`  out  1  one-cycle pulse, pixel complete
- `pix_x`  out  7  pixel column
- `pix_y`  out  7  pixel row
- `pix_color`  out  16  RGB565 pixel, {r[4:0], g[5:0], b[4:0]}

## Operation
- Edge detect: `spi_clk` is registered to `sclk_q`. A rising edge is `spi_clk & ~sclk_q` while `spi_csn` = 0. No synchronizers are used. The input must hold each level for ≥1 clk, so `spi_clk` = clk/2 is the maximum rate.
- Shifter: on each rising edge, `{sr, spi_mosi}` is shifted in and the 3-bit bit counter increments. On the 8th bit, the byte and DC are latched.
- `spi_csn` high clears the bit counter. A partial byte is discarded with no strobe. Decoder state is kept across CS deassertion.
- Command FSM states: IDLE, CADDR0, CADDR1, RADDR0, RADDR1, WRAM, SKIP.
  - A command byte (dc = 0) always resets the FSM. 0x15 → CADDR0, 0x75 → RADDR0, 0x5C → WRAM, any other value → SKIP.
  - CADDR0: data byte → `col_start`, next CADDR1. CADDR1: data byte → `col_end`, next SKIP. Further data bytes are ignored.
  - RADDR0/RADDR1: same for `row_start`/`row_end`.
  - Entering CADDR or RADDR loads the matching pointer with the start value once CADDR1/RADDR1 completes.
  - SKIP and IDLE ignore data bytes.
- WRAM pixel assembly:
  - The first data byte goes to `pix_hi` and toggles the phase.
  - The second data byte completes the pixel: color = {pix_hi, byte}, coordinates = {col_ptr, row_ptr}, then the pointers advance.
  - Entering WRAM resets the phase to high byte and sets `col_ptr` = `col_start`, `row_ptr` = `row_start`.
- Address advance:
  - If `col_ptr` == `col_end`: `col_ptr` ← `col_start`, and the row advances. Otherwise `col_ptr` ← (`col_ptr`+1) mod `c_x_size`.
  - Row advance: if `row_ptr` == `row_end`, `row_ptr` ← `row_start`. Otherwise (`row_ptr`+1) mod `c_y_size`.
  - start > end is legal and wraps through 0.
- Address bytes are truncated to log2(size) bits. Pointers and outputs are zero-extended to 7 bits.
- `spi_resn` = 0: FSM → IDLE, shifter and phase clear, window returns to the reset values. Strobes are forced to 0 that cycle.

## Timing
- Reset values:
  - FSM = IDLE, bit counter 0, phase high.
  - `col_start` = `row_start` = 0, `col_end` = `c_x_size`-1, `row_end` = `c_y_size`-1, pointers 0.
  - All outputs 0.
- Latencies, where cycle N is the cycle in which the 8th rising edge is detected:
  - `byte_valid`, `byte_data` and `byte_dc` update in cycle N+1.
  - `pix_valid`, `pix_x`, `pix_y` and `pix_color` update in N+2.
- `byte_data`, `byte_dc`, `pix_x`, `pix_y` and `pix_color` hold their value until the next strobe.
- A command byte arriving while a pixel high byte is pending drops that half-pixel.
- `spi_resn` low during a byte: no `byte_valid` is produced for that byte.
- Asynchronous `rst` mid-stream: all state and outputs clear immediately. Decoding resumes at the next byte boundary after CS toggles.

## Test plan
- Reset: `rst` = 0 with random SPI activity → all outputs 0. Release, send 0x5C then 0xF8,0x00 → `pix_valid` with x = 0, y = 0, color = 0xF800.
- Window: 0x15 {0x10,0x11}, 0x75 {0x20,0x21}, 0x5C + 5 pixels → (16,32),(17,32),(16,33),(17,33),(16,32).
- Full frame: 0x5C + 128×128 pixels with color = index → a 16384-pixel raster in order. The last pixel is (127,127) and the next pixel is (0,0).
- Byte latency: spi_clk = clk/2, one data byte 0xA5 → `byte_valid` exactly 1 cycle after the 8th rising edge, `byte_data` = 0xA5, `byte_dc` = 1.
- Interruptions:
  - CS high after 3 bits → no strobe, and the next full byte decodes correctly.
  - Command 0x5C after a single data byte → the half-pixel is dropped and the next pixel lands at (`col_start`,`row_start`).
- Unknown command 0xAF followed by data 0x12,0x34 → no `pix_valid`, two `byte_valid`.
